// File: rtl/comparator_stream_if.sv
// Stream interface for comparator_stream: sample/reference/mode inputs,
// synchronous clear, and the registered match/run/hit/state outputs.
interface comparator_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] ref_val;
  logic [1:0]       mode;
  logic [CNT_W-1:0] threshold;

  logic             out_valid;
  logic             out;
  logic [CNT_W-1:0] run_cnt;
  logic             hit;
  logic [1:0]       state;

  // Stimulus side: drives samples and configuration, observes results.
  modport master (
    output clear, in_valid, in, ref_val, mode, threshold,
    input  out_valid, out, run_cnt, hit, state
  );

  // Comparator side.
  modport slave (
    input  clear, in_valid, in, ref_val, mode, threshold,
    output out_valid, out, run_cnt, hit, state
  );
endinterface

// File: rtl/comparator_stream.sv
// comparator_stream: registered zero/limit watchdog. Compares each accepted
// sample against zero or ref_val (eq/gt/lt, unsigned), counts consecutive
// matches in a saturating run counter and locks (hit=1) once the run reaches
// a programmable threshold (threshold=0 disables the lock).
// Optional build macro CMP_STREAM_STICKY_EN: when defined, LOCK is left only
// via clear or reset; otherwise an accepted mismatch drops LOCK to IDLE.
module comparator_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  comparator_stream_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LOCK = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             match;
  logic             hit_cond;

  // Compare the current sample according to mode (all compares unsigned).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    match = 1'b0;
    case (bus.mode)
      2'b00: match = (bus.in == '0);
      2'b01: match = (bus.in == bus.ref_val);
      2'b10: match = (bus.in >  bus.ref_val);
      2'b11: match = (bus.in <  bus.ref_val);
    endcase
  end

  // Run length after this sample (saturating) and the lock condition on it.
  always_comb begin
    cnt_next = '0;
    if (match) begin
      cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
    hit_cond = (bus.threshold != '0) && (cnt_next >= bus.threshold);
  end

  // Next-state and next-output decode; clear outranks an accepted sample.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;

    if (bus.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      out_d   = 1'b0;
    end else if (bus.in_valid) begin
      out_valid_d = 1'b1;
      out_d       = match;
      cnt_d       = cnt_next;
      case (state_q)
        IDLE: begin
          if (match) state_d = hit_cond ? LOCK : RUN;
        end
        RUN: begin
          if (!match)        state_d = IDLE;
          else if (hit_cond) state_d = LOCK;
        end
        LOCK: begin
`ifdef CMP_STREAM_STICKY_EN
          // Sticky lock: a mismatch restarts the run but keeps hit asserted.
          state_d = LOCK;
`else
          if (!match) state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.run_cnt   = cnt_q;
  assign bus.hit       = (state_q == LOCK);
  assign bus.state     = state_q;

endmodule
